// File: rtl/bin2bcd_chan.sv
// Multi-channel binary-to-BCD converter: shift-add-3 over all channels in lockstep, registered results.
// Optional BCD_BLANK_EN macro replaces leading zero digits with 4'hF.
module bin2bcd_chan #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 2,
    parameter int CHANNELS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CHANNELS*WIDTH-1:0]    bin_in,
    output logic                         busy,
    output logic                         done,
    output logic [CHANNELS*DIGITS*4-1:0] bcd_out,
    output logic [CHANNELS-1:0]          ovf
);

    // Accumulator holds 2^WIDTH-1 whatever DIGITS is; ceil(WIDTH/3) digits always suffice.
    localparam int ACC_DIGITS = (WIDTH + 2) / 3;
    localparam int ACC_W      = ACC_DIGITS * 4;
    localparam int MAXD       = (ACC_DIGITS > DIGITS) ? ACC_DIGITS : DIGITS;
    localparam int OUT_W      = DIGITS * 4;
    localparam int CW         = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_bin     [CHANNELS];
    logic [ACC_W-1:0]       r_acc     [CHANNELS];
    logic [WIDTH-1:0]       w_bin_nxt [CHANNELS];
    logic [ACC_W-1:0]       w_acc_nxt [CHANNELS];
    logic [CHANNELS*OUT_W-1:0] w_bcd;
    logic [CHANNELS-1:0]    w_ovf;
    logic                   w_last;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    function automatic logic [ACC_W+WIDTH-1:0] ddStep(input logic [ACC_W-1:0] acc,
                                                      input logic [WIDTH-1:0] bin);
        logic [ACC_W-1:0] adj;
        adj = acc;
        for (int d = 0; d < ACC_DIGITS; d++) begin
            if (adj[d*4 +: 4] >= 4'd5)
                adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
        end
        return {adj, bin} << 1;
    endfunction

    // Returns {overflow, digits}; saturated channels are never blanked.
    function automatic logic [OUT_W:0] fmtDigits(input logic [ACC_W-1:0] acc);
        logic [MAXD*4-1:0] pad;
        logic [OUT_W-1:0]  dig;
        logic              ov;
`ifdef BCD_BLANK_EN
        logic              seen;
`endif
        pad = (MAXD*4)'(acc);
        ov  = 1'b0;
        for (int d = DIGITS; d < MAXD; d++) begin
            if (pad[d*4 +: 4] != 4'd0)
                ov = 1'b1;
        end
        dig = pad[OUT_W-1:0];
        if (ov) begin
            dig = {DIGITS{4'h9}};
        end
`ifdef BCD_BLANK_EN
        else begin
            seen = 1'b0;
            for (int d = DIGITS - 1; d > 0; d--) begin
                if (dig[d*4 +: 4] != 4'd0)
                    seen = 1'b1;
                if (!seen)
                    dig[d*4 +: 4] = 4'hF;
            end
        end
`endif
        return {ov, dig};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_bcd = '0;
        w_ovf = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            {w_acc_nxt[c], w_bin_nxt[c]} = ddStep(r_acc[c], r_bin[c]);
            {w_ovf[c], w_bcd[c*OUT_W +: OUT_W]} = fmtDigits(w_acc_nxt[c]);
        end
    end

    // Results load from the final shift so they appear on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            ovf     <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_bin[c] <= '0;
                r_acc[c] <= '0;
            end
        end else begin
            busy <= (w_next != IDLE);
            done <= (w_next == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt <= '0;
                        for (int c = 0; c < CHANNELS; c++) begin
                            r_bin[c] <= bin_in[c*WIDTH +: WIDTH];
                            r_acc[c] <= '0;
                        end
                    end
                end
                SHIFT: begin
                    r_cnt <= r_cnt + 1'b1;
                    for (int c = 0; c < CHANNELS; c++) begin
                        r_bin[c] <= w_bin_nxt[c];
                        r_acc[c] <= w_acc_nxt[c];
                    end
                    if (w_last) begin
                        bcd_out <= w_bcd;
                        ovf     <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_chan.sv
// Scoreboard bench for bin2bcd_chan at default parameters (8-bit, 2 digits, 3 channels).
// Expected BCD words are hand-computed; blanked variants apply when BCD_BLANK_EN is defined.
module tb_bin2bcd_chan;

    localparam int W  = 8;
    localparam int D  = 2;
    localparam int C  = 3;
    localparam int BW = C * W;
    localparam int OW = C * D * 4;

`ifdef BCD_BLANK_EN
    localparam logic [OW-1:0] EXP_A    = 24'h59F799;
    localparam logic [OW-1:0] EXP_ZERO = 24'hF0F0F0;
    localparam logic [OW-1:0] EXP_SEV  = 24'hF799F0;
    localparam logic [OW-1:0] EXP_123  = 24'hF1F2F3;
`else
    localparam logic [OW-1:0] EXP_A    = 24'h590799;
    localparam logic [OW-1:0] EXP_ZERO = 24'h000000;
    localparam logic [OW-1:0] EXP_SEV  = 24'h079900;
    localparam logic [OW-1:0] EXP_123  = 24'h010203;
`endif

    typedef struct {
        logic [OW-1:0] bcd;
        logic [C-1:0]  ovf;
        int            cyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [BW-1:0] bin_in;
    logic          busy;
    logic          done;
    logic [OW-1:0] bcd_out;
    logic [C-1:0]  ovf;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    bin2bcd_chan #(.WIDTH(W), .DIGITS(D), .CHANNELS(C)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding conversion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected no pulse at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    checkOutput("bcd_out", 64'(bcd_out), 64'(e.bcd));
                    checkOutput("ovf", 64'(ovf), 64'(e.ovf));
                    checkOutput("latency", 64'(cyc - e.cyc), 64'(W));
                end
            end
        end
    end

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
        checkOutput("busy_idle", 64'(busy), 64'd0);
    endtask

    task automatic applyStimulus(input logic [BW-1:0] vals, input logic [OW-1:0] expBcd,
                                 input logic [C-1:0] expOvf);
        exp_t e;
        @(negedge clk);
        bin_in = vals;
        start  = 1'b1;
        @(posedge clk);
        #1;
        e.bcd = expBcd;
        e.ovf = expOvf;
        e.cyc = cyc;
        sb.push_back(e);
        checkOutput("busy_shift", 64'(busy), 64'd1);
        @(negedge clk);
        start  = 1'b0;
        bin_in = ~vals;
        waitDrain();
    endtask

    initial begin
        exp_t e;
        rst    = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_bcd", 64'(bcd_out), 64'd0);
        checkOutput("reset_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);

        applyStimulus({8'd59, 8'd7, 8'd99}, EXP_A, 3'b000);
        applyStimulus({8'd10, 8'd42, 8'd255}, 24'h104299, 3'b001);
        applyStimulus({8'd0, 8'd0, 8'd0}, EXP_ZERO, 3'b000);
        applyStimulus({8'd7, 8'd100, 8'd0}, EXP_SEV, 3'b010);
        applyStimulus({8'd200, 8'd128, 8'd10}, 24'h999910, 3'b110);

        // Start held high: second capture lands 10 edges after the first, mid-run inputs ignored.
        @(negedge clk);
        bin_in = {8'd1, 8'd2, 8'd3};
        start  = 1'b1;
        @(posedge clk);
        #1;
        e.bcd = EXP_123;
        e.ovf = 3'b000;
        e.cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        bin_in = {8'd88, 8'd88, 8'd88};
        repeat (9) @(posedge clk);
        @(negedge clk);
        bin_in = {8'd45, 8'd67, 8'd89};
        @(posedge clk);
        #1;
        e.bcd = 24'h456789;
        e.ovf = 3'b000;
        e.cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        bin_in = {8'd88, 8'd88, 8'd88};
        waitDrain();

        // Abort three cycles into SHIFT; no done may follow.
        @(negedge clk);
        bin_in = {8'd59, 8'd7, 8'd99};
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_bcd", 64'(bcd_out), 64'd0);
        checkOutput("abort_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(posedge clk);
        applyStimulus({8'd12, 8'd34, 8'd56}, 24'h123456, 3'b000);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
